// File: rtl/riscv_ex_pkg.sv
// Shared execute-stage definitions: ALU codes, M-op decode, FSM and forwarding encodings.
package riscv_ex_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_LUI  = 5'd10;

  localparam logic [4:0] MD_MUL    = 5'd16;
  localparam logic [4:0] MD_MULH   = 5'd17;
  localparam logic [4:0] MD_MULHSU = 5'd18;
  localparam logic [4:0] MD_MULHU  = 5'd19;
  localparam logic [4:0] MD_DIV    = 5'd20;
  localparam logic [4:0] MD_DIVU   = 5'd21;
  localparam logic [4:0] MD_REM    = 5'd22;
  localparam logic [4:0] MD_REMU   = 5'd23;

  // Low three bits of an M-op ALUCode
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } md_op_e;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

  typedef enum logic [1:0] {FWD_RF, FWD_WB, FWD_MEM} fwd_sel_e;

  function automatic logic is_mdop(input logic [7:0] code);
    return (code >= 8'(MD_MUL)) && (code <= 8'(MD_REMU));
  endfunction

  function automatic logic is_div(input md_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_a(input md_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input md_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv_stage_muldiv_iter.sv
// Iterative radix-2 multiply/divide on operand magnitudes with sign fix-up at the end.
module muldiv_iter
  import riscv_ex_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  md_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            active,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state, state_next;
  logic [CW-1:0]   count;
  md_op_e          op_r;
  logic            sa_r, sb_r, dz_r, ovf_r;
  logic [XLEN-1:0] a_r, b_r, lo;
  logic [XLEN:0]   hi;

  logic            sa, sb;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum, div_sh;
  logic [XLEN+1:0] div_diff;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quot, rem;

  assign sa    = is_signed_a(op) && a[XLEN-1];
  assign sb    = is_signed_b(op) && b[XLEN-1];
  assign a_mag = sa ? -a : a;
  assign b_mag = sb ? -b : b;

  // hi:lo is the product accumulator for multiply, remainder:quotient for divide
  assign mul_sum  = hi + (lo[0] ? {1'b0, b_r} : '0);
  assign div_sh   = {hi[XLEN-1:0], lo[XLEN-1]};
  assign div_diff = {1'b0, div_sh} - {2'b00, b_r};

  // Next-state logic; flush overrides everything
  always_comb begin
    state_next = state;
    unique case (state)
      MD_IDLE: if (start) state_next = MD_BUSY;
      MD_BUSY: if (count == CW'(1)) state_next = MD_DONE;
      MD_DONE: state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
    if (flush) state_next = MD_IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_next;
  end

  // Operand latch on start, then one shift-add / restoring-subtract step per BUSY cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      op_r  <= OP_MUL;
      sa_r  <= 1'b0;
      sb_r  <= 1'b0;
      dz_r  <= 1'b0;
      ovf_r <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      lo    <= '0;
      hi    <= '0;
    end else if (state == MD_IDLE && state_next == MD_BUSY) begin
      count <= CW'(XLEN);
      op_r  <= op;
      sa_r  <= sa;
      sb_r  <= sb;
      dz_r  <= (b == '0);
      ovf_r <= is_div(op) && is_signed_a(op) && (a == MIN) && (b == '1);
      a_r   <= a;
      b_r   <= b_mag;
      lo    <= a_mag;
      hi    <= '0;
    end else if (state == MD_BUSY) begin
      count <= count - 1'b1;
      if (is_div(op_r)) begin
        if (!div_diff[XLEN+1]) begin
          hi <= div_diff[XLEN:0];
          lo <= {lo[XLEN-2:0], 1'b1};
        end else begin
          hi <= div_sh;
          lo <= {lo[XLEN-2:0], 1'b0};
        end
      end else begin
        hi <= {1'b0, mul_sum[XLEN:1]};
        lo <= {mul_sum[0], lo[XLEN-1:1]};
      end
    end
  end

  assign prod   = {hi[XLEN-1:0], lo};
  assign prod_s = (sa_r ^ sb_r) ? -prod : prod;
  assign quot   = (sa_r ^ sb_r) ? -lo : lo;
  assign rem    = sa_r ? -hi[XLEN-1:0] : hi[XLEN-1:0];

  // Signed-corrected result, only presented in DONE
  always_comb begin
    result = '0;
    if (state == MD_DONE) begin
      unique case (op_r)
        OP_MUL:                       result = prod_s[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: result = prod_s[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU:              result = dz_r ? '1 : (ovf_r ? MIN : quot);
        OP_REM, OP_REMU:              result = dz_r ? a_r : (ovf_r ? '0 : rem);
        default:                      result = '0;
      endcase
    end
  end

  assign active = (state != MD_IDLE);
  assign busy   = (state == MD_BUSY);
  assign done   = (state == MD_DONE);

endmodule

// File: rtl/ex_muldiv_stage.sv
// Execute stage: forwarding, operand muxes, single-cycle ALU and iterative RV32M unit.
module ex_muldiv_stage
  import riscv_ex_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ALUCODE_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_ex,
  input  logic                 flush_ex,
  input  logic [ALUCODE_W-1:0] ALUCode_ex,
  input  logic                 ALUSrcA_ex,
  input  logic [1:0]           ALUSrcB_ex,
  input  logic [XLEN-1:0]      Imm_ex,
  input  logic [4:0]           rs1Addr_ex,
  input  logic [4:0]           rs2Addr_ex,
  input  logic [XLEN-1:0]      rs1Data_ex,
  input  logic [XLEN-1:0]      rs2Data_ex,
  input  logic [XLEN-1:0]      PC_ex,
  input  logic [XLEN-1:0]      ALUResult_mem,
  input  logic [XLEN-1:0]      RegWriteData_wb,
  input  logic [4:0]           rdAddr_mem,
  input  logic [4:0]           rdAddr_wb,
  input  logic                 RegWrite_mem,
  input  logic                 RegWrite_wb,
  output logic [XLEN-1:0]      ALUResult_ex,
  output logic [XLEN-1:0]      MemWriteData_ex,
  output logic [XLEN-1:0]      ALU_A,
  output logic [XLEN-1:0]      ALU_B,
  output logic                 stall_ex,
  output logic                 md_busy
);

  localparam int unsigned SW = $clog2(XLEN);

  fwd_sel_e        fwd_a, fwd_b;
  logic [XLEN-1:0] fa, fb, alu_y, md_result;
  logic [SW-1:0]   shamt;
  logic            md_code, md_start, md_active, md_run, md_done;

  // Forward select: MEM written last so it beats WB
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (RegWrite_wb && rdAddr_wb != 5'd0 && rdAddr_wb == rs1Addr_ex) fwd_a = FWD_WB;
    if (RegWrite_wb && rdAddr_wb != 5'd0 && rdAddr_wb == rs2Addr_ex) fwd_b = FWD_WB;
    if (RegWrite_mem && rdAddr_mem != 5'd0 && rdAddr_mem == rs1Addr_ex) fwd_a = FWD_MEM;
    if (RegWrite_mem && rdAddr_mem != 5'd0 && rdAddr_mem == rs2Addr_ex) fwd_b = FWD_MEM;
  end

  // Forwarded register operands and ALU source muxes
  always_comb begin
    unique case (fwd_a)
      FWD_WB:  fa = RegWriteData_wb;
      FWD_MEM: fa = ALUResult_mem;
      default: fa = rs1Data_ex;
    endcase
    unique case (fwd_b)
      FWD_WB:  fb = RegWriteData_wb;
      FWD_MEM: fb = ALUResult_mem;
      default: fb = rs2Data_ex;
    endcase
    ALU_A = ALUSrcA_ex ? PC_ex : fa;
    unique case (ALUSrcB_ex)
      2'd0:    ALU_B = fb;
      2'd1:    ALU_B = Imm_ex;
      2'd2:    ALU_B = XLEN'(4);
      default: ALU_B = '0;
    endcase
  end

  assign MemWriteData_ex = fb;
  assign shamt           = ALU_B[SW-1:0];

  // Single-cycle ALU for codes 0-15
  always_comb begin
    alu_y = '0;
    case (ALUCode_ex)
      ALUCODE_W'(ALU_ADD):  alu_y = ALU_A + ALU_B;
      ALUCODE_W'(ALU_SUB):  alu_y = ALU_A - ALU_B;
      ALUCODE_W'(ALU_SLL):  alu_y = ALU_A << shamt;
      ALUCODE_W'(ALU_SLT):  alu_y = {{(XLEN-1){1'b0}}, $signed(ALU_A) < $signed(ALU_B)};
      ALUCODE_W'(ALU_SLTU): alu_y = {{(XLEN-1){1'b0}}, ALU_A < ALU_B};
      ALUCODE_W'(ALU_XOR):  alu_y = ALU_A ^ ALU_B;
      ALUCODE_W'(ALU_SRL):  alu_y = ALU_A >> shamt;
      ALUCODE_W'(ALU_SRA):  alu_y = $unsigned($signed(ALU_A) >>> shamt);
      ALUCODE_W'(ALU_OR):   alu_y = ALU_A | ALU_B;
      ALUCODE_W'(ALU_AND):  alu_y = ALU_A & ALU_B;
      ALUCODE_W'(ALU_LUI):  alu_y = ALU_B;
      default:              alu_y = '0;
    endcase
  end

  assign md_code  = is_mdop(8'(ALUCode_ex));
  assign md_start = valid_ex && md_code && !flush_ex && !reset;

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .flush  (flush_ex),
    .op     (md_op_e'(ALUCode_ex[2:0])),
    .a      (fa),
    .b      (fb),
    .active (md_active),
    .busy   (md_run),
    .done   (md_done),
    .result (md_result)
  );

  // Stall covers the start cycle (IDLE + start) and all BUSY cycles; flush wins
  assign stall_ex = !flush_ex && !reset && (md_run || (md_start && !md_active));
  assign md_busy  = md_active;

  // Result mux: M-op result only in DONE, zero while an M-op is pending
  always_comb begin
    if (md_done)              ALUResult_ex = flush_ex ? '0 : md_result;
    else if (md_code || md_run) ALUResult_ex = '0;
    else                      ALUResult_ex = alu_y;
  end

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Directed self-checking bench for ex_muldiv_stage.
module tb_ex_muldiv_stage;
  import riscv_ex_pkg::*;

  logic        clk = 1'b0;
  logic        reset, valid_ex, flush_ex, ALUSrcA_ex;
  logic [4:0]  ALUCode_ex;
  logic [1:0]  ALUSrcB_ex;
  logic [31:0] Imm_ex, rs1Data_ex, rs2Data_ex, PC_ex, ALUResult_mem, RegWriteData_wb;
  logic [4:0]  rs1Addr_ex, rs2Addr_ex, rdAddr_mem, rdAddr_wb;
  logic        RegWrite_mem, RegWrite_wb;
  logic [31:0] ALUResult_ex, MemWriteData_ex, ALU_A, ALU_B;
  logic        stall_ex, md_busy;

  int total = 0;
  int bad   = 0;

  ex_muldiv_stage #(.XLEN(32), .ALUCODE_W(5)) dut (
    .clk(clk), .reset(reset), .valid_ex(valid_ex), .flush_ex(flush_ex),
    .ALUCode_ex(ALUCode_ex), .ALUSrcA_ex(ALUSrcA_ex), .ALUSrcB_ex(ALUSrcB_ex),
    .Imm_ex(Imm_ex), .rs1Addr_ex(rs1Addr_ex), .rs2Addr_ex(rs2Addr_ex),
    .rs1Data_ex(rs1Data_ex), .rs2Data_ex(rs2Data_ex), .PC_ex(PC_ex),
    .ALUResult_mem(ALUResult_mem), .RegWriteData_wb(RegWriteData_wb),
    .rdAddr_mem(rdAddr_mem), .rdAddr_wb(rdAddr_wb),
    .RegWrite_mem(RegWrite_mem), .RegWrite_wb(RegWrite_wb),
    .ALUResult_ex(ALUResult_ex), .MemWriteData_ex(MemWriteData_ex),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .stall_ex(stall_ex), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_ex = 1'b0; flush_ex = 1'b0; ALUCode_ex = ALU_ADD;
    ALUSrcA_ex = 1'b0; ALUSrcB_ex = 2'd0; Imm_ex = '0; PC_ex = '0;
    rs1Addr_ex = '0; rs2Addr_ex = '0; rs1Data_ex = '0; rs2Data_ex = '0;
    ALUResult_mem = '0; RegWriteData_wb = '0; rdAddr_mem = '0; rdAddr_wb = '0;
    RegWrite_mem = 1'b0; RegWrite_wb = 1'b0;
  endtask

  // Issue one M-op from the register file, count stall cycles, check the DONE result
  task automatic run_mop(input string tag, input logic [4:0] code,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n;
    valid_ex = 1'b1; ALUCode_ex = code;
    rs1Addr_ex = 5'd1; rs2Addr_ex = 5'd2; rs1Data_ex = a; rs2Data_ex = b;
    #1;
    check({tag, "_c0_stall"}, 32'(stall_ex), 32'd1);
    check({tag, "_c0_res"}, ALUResult_ex, 32'd0);
    n = 0;
    while (stall_ex === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check({tag, "_stall_cycles"}, 32'(n), 32'd33);
    check({tag, "_result"}, ALUResult_ex, exp);
    check({tag, "_done_busy"}, 32'(md_busy), 32'd1);
    tick();
    valid_ex = 1'b0;
    #1;
    check({tag, "_idle"}, 32'(md_busy), 32'd0);
  endtask

  initial begin
    int n;
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    check("rst_stall", 32'(stall_ex), 32'd0);
    check("rst_busy", 32'(md_busy), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_res", ALUResult_ex, 32'd0);

    // Forwarding priority: MEM over WB over register file
    ALUCode_ex = ALU_ADD; valid_ex = 1'b1;
    rs1Addr_ex = 5'd5; rs2Addr_ex = 5'd0; rs1Data_ex = 32'h99; rs2Data_ex = 32'h0;
    rdAddr_mem = 5'd5; ALUResult_mem = 32'h11; RegWrite_mem = 1'b1;
    rdAddr_wb  = 5'd5; RegWriteData_wb = 32'h22; RegWrite_wb = 1'b1;
    #1;
    check("fwd_mem", ALUResult_ex, 32'h11);
    check("fwd_mem_a", ALU_A, 32'h11);
    RegWrite_mem = 1'b0; #1;
    check("fwd_wb", ALUResult_ex, 32'h22);
    RegWrite_mem = 1'b1; rdAddr_mem = 5'd0; rdAddr_wb = 5'd0; #1;
    check("fwd_rd0", ALUResult_ex, 32'h99);
    rs2Addr_ex = 5'd7; rdAddr_wb = 5'd7; RegWriteData_wb = 32'h1234; #1;
    check("fwd_store", MemWriteData_ex, 32'h1234);
    check("fwd_stall", 32'(stall_ex), 32'd0);

    // PC + 4 and immediate operand select
    idle_inputs(); valid_ex = 1'b1;
    ALUSrcA_ex = 1'b1; ALUSrcB_ex = 2'd2; PC_ex = 32'h100; #1;
    check("pc4", ALUResult_ex, 32'h104);
    check("pc4_b", ALU_B, 32'h4);
    ALUSrcA_ex = 1'b0; ALUSrcB_ex = 2'd1; rs1Data_ex = 32'h10; Imm_ex = 32'hFFFF_FFFF;
    ALUCode_ex = ALU_SUB; #1;
    check("sub_imm", ALUResult_ex, 32'h11);

    // Bubble with an M-code must not start
    idle_inputs(); ALUCode_ex = MD_MUL; #1;
    check("bubble_stall", 32'(stall_ex), 32'd0);
    tick();
    check("bubble_busy", 32'(md_busy), 32'd0);

    idle_inputs();
    run_mop("mul",    MD_MUL,   32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_mop("mulhu",  MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_mop("mulh",   MD_MULH,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_mop("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
    run_mop("div0",   MD_DIV,   32'd7,        32'd0,         32'hFFFF_FFFF);
    run_mop("remu0",  MD_REMU,  32'd7,        32'd0,         32'd7);
    run_mop("divovf", MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_mop("removf", MD_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_mop("divneg", MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_mop("remneg", MD_REM,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_mop("divu",   MD_DIVU,  32'd100,      32'd7,         32'd14);

    // Forward-then-stall: rs1 from MEM only in the start cycle
    idle_inputs(); valid_ex = 1'b1; ALUCode_ex = MD_MUL;
    rs1Addr_ex = 5'd1; rs2Addr_ex = 5'd2; rs1Data_ex = 32'hDEAD; rs2Data_ex = 32'd3;
    rdAddr_mem = 5'd1; ALUResult_mem = 32'h10; RegWrite_mem = 1'b1;
    #1;
    check("fts_c0_stall", 32'(stall_ex), 32'd1);
    tick();
    RegWrite_mem = 1'b0; ALUResult_mem = 32'h0; rdAddr_mem = 5'd0;
    n = 1;
    while (stall_ex === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("fts_cycles", 32'(n), 32'd33);
    check("fts_result", ALUResult_ex, 32'h30);
    tick();
    valid_ex = 1'b0;

    // Flush at BUSY cycle 10
    idle_inputs(); valid_ex = 1'b1; ALUCode_ex = MD_MUL;
    rs1Addr_ex = 5'd1; rs2Addr_ex = 5'd2; rs1Data_ex = 32'd7; rs2Data_ex = 32'd9;
    #1;
    check("fl_c0_stall", 32'(stall_ex), 32'd1);
    repeat (10) tick();
    check("fl_busy", 32'(md_busy), 32'd1);
    check("fl_stall_pre", 32'(stall_ex), 32'd1);
    flush_ex = 1'b1; #1;
    check("fl_stall_drop", 32'(stall_ex), 32'd0);
    tick();
    flush_ex = 1'b0; ALUCode_ex = ALU_ADD; rs1Data_ex = 32'd5; rs2Data_ex = 32'd6; #1;
    check("fl_add_stall", 32'(stall_ex), 32'd0);
    check("fl_add_busy", 32'(md_busy), 32'd0);
    check("fl_add_res", ALUResult_ex, 32'd11);

    // Reset at BUSY cycle 5 abandons the op
    tick();
    ALUCode_ex = MD_MUL; rs1Data_ex = 32'd7; rs2Data_ex = 32'd9; #1;
    check("rm_c0_stall", 32'(stall_ex), 32'd1);
    repeat (5) tick();
    check("rm_busy_pre", 32'(md_busy), 32'd1);
    reset = 1'b1;
    tick();
    check("rm_stall", 32'(stall_ex), 32'd0);
    check("rm_busy", 32'(md_busy), 32'd0);
    check("rm_res", ALUResult_ex, 32'd0);
    reset = 1'b0; valid_ex = 1'b0;
    tick();
    idle_inputs();
    run_mop("post_rst", MD_MUL, 32'd6, 32'd7, 32'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
